// File: rtl/bin2bcd_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bin2bcd_seq_pkg : shared constants for the sequential BCD converter   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package bin2bcd_seq_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADD3_THRESH = 5;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // All-nines pattern for up to 16 digits; callers slice to their width.
  function automatic logic [63:0] bcd_nines(input int digits);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < digits) r[i*4 +: 4] = 4'h9;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_add3_digit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_add3_digit : combinational "if >= 5 then +3" double-dabble cell   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bcd_add3_digit
  import bin2bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  localparam logic [BCD_DIGIT_W-1:0] c_THRESH = BCD_DIGIT_W'(ADD3_THRESH);
  localparam logic [BCD_DIGIT_W-1:0] c_ADJ    = BCD_DIGIT_W'(3);

  assign o_digit = (i_digit >= c_THRESH) ? (i_digit + c_ADJ) : i_digit;

endmodule
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bin2bcd_seq : one-bit-per-clock double-dabble binary to packed BCD    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W   = 14,
  parameter int DIGITS  = 4,
  parameter int MAX_VAL = 9999
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_in,
  input  logic [BIN_W-1:0]              bin_in,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          ovf_o
);

  localparam int c_BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int c_CAT_W = c_BCD_W + BIN_W;
  localparam int c_CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(BIN_W - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [BIN_W-1:0]   c_MAX_BIN  = BIN_W'(MAX_VAL);
  localparam logic [c_BCD_W-1:0] c_NINES    = c_BCD_W'(bcd_nines(DIGITS));

  logic [0:0]         r_state;
  logic [BIN_W-1:0]   r_shift;
  logic [c_BCD_W-1:0] r_scratch;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_ovf_pend;
  logic [c_BCD_W-1:0] r_bcd;
  logic               r_busy;
  logic               r_done;
  logic               r_ovf;

  logic [c_BCD_W-1:0] w_adj;
  logic [c_CAT_W-1:0] w_cat_sh;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .i_digit (r_scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Any carry out of the top digit is dropped; it only occurs for saturated operands.
  assign w_cat_sh = {w_adj, r_shift} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_bcd      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_in) begin
            r_state    <= ST_SHIFT;
            r_shift    <= bin_in;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= (bin_in > c_MAX_BIN);
            r_busy     <= 1'b1;
          end
        end
        ST_SHIFT: begin
          r_shift   <= w_cat_sh[BIN_W-1:0];
          r_scratch <= w_cat_sh[c_CAT_W-1:BIN_W];
          r_cnt     <= r_cnt + c_CNT_ONE;
          if (r_cnt == c_LAST_CNT) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_ovf   <= r_ovf_pend;
            r_bcd   <= r_ovf_pend ? c_NINES : w_cat_sh[c_CAT_W-1:BIN_W];
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bcd_o  = r_bcd;
  assign busy_o = r_busy;
  assign done_o = r_done;
  assign ovf_o  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bin2bcd_seq : randomized self-checking bench for bin2bcd_seq       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_bin2bcd_seq;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        start_in = 1'b0;
  logic [13:0] bin_in   = '0;
  logic [15:0] bcd_o;
  logic        busy_o;
  logic        done_o;
  logic        ovf_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(14), .DIGITS(4), .MAX_VAL(9999)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_in (start_in),
    .bin_in   (bin_in),
    .bcd_o    (bcd_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .ovf_o    (ovf_o)
  );

  // Decimal digits by plain division; saturates to all nines above 9999.
  function automatic logic [15:0] ref_bcd(input int v);
    int t;
    logic [15:0] r;
    if (v > 9999) return 16'h9999;
    t = v;
    for (int d = 0; d < 4; d++) begin
      r[d*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [13:0] rand14();
    if ($urandom % 8 == 0) return 14'($urandom_range(16383, 10000));
    return 14'($urandom_range(9999, 0));
  endfunction

  // One isolated conversion; returns what was observed (latency in edges after accept).
  task automatic run_conv(input logic [13:0] v, output logic [15:0] bcd, output logic ovf,
                          output int lat, output int busy_n, output logic held,
                          output logic done_after);
    logic [15:0] prev;
    int k;
    @(negedge clk);
    prev = bcd_o; start_in = 1'b1; bin_in = v;
    @(negedge clk);
    start_in = 1'b0; bin_in = 14'($urandom);
    lat = -1; busy_n = 0; held = 1'b1; k = 1; bcd = 'x; ovf = 1'bx;
    while (k <= 40 && lat < 0) begin
      if (busy_o) busy_n++;
      if (done_o) begin
        lat = k - 1; bcd = bcd_o; ovf = ovf_o;
      end else begin
        if (bcd_o !== prev) held = 1'b0;
        @(negedge clk); k++;
      end
    end
    @(negedge clk);
    done_after = done_o;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bcd_o !== 16'h0) begin bad++; $display("FAIL reset_bcd: got %h want 0000", bcd_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done_o); end
    total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf_o); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if ({busy_o, done_o} !== 2'b00) begin bad++; $display("FAIL idle_after_reset: got %b want 00", {busy_o, done_o}); end
  endtask

  task automatic test_zero();
    logic [15:0] b; logic o, h, da; int lat, bn;
    run_conv(14'd0, b, o, lat, bn, h, da);
    total++; if (b !== 16'h0000) begin bad++; $display("FAIL zero_bcd: got %h want 0000", b); end
    total++; if (o !== 1'b0) begin bad++; $display("FAIL zero_ovf: got %b want 0", o); end
    total++; if (lat != 14) begin bad++; $display("FAIL zero_latency: got %0d want 14", lat); end
    total++; if (bn != 14) begin bad++; $display("FAIL zero_busy_cycles: got %0d want 14", bn); end
    total++; if (da !== 1'b0) begin bad++; $display("FAIL zero_done_width: got %b want 0", da); end
  endtask

  task automatic test_1234();
    logic [15:0] b; logic o, h, da; int lat, bn;
    run_conv(14'd1234, b, o, lat, bn, h, da);
    total++; if (b !== 16'h1234) begin bad++; $display("FAIL conv_1234: got %h want 1234", b); end
    total++; if (h !== 1'b1) begin bad++; $display("FAIL hold_before_1234: got %b want 1", h); end
    total++; if (lat != 14) begin bad++; $display("FAIL latency_1234: got %0d want 14", lat); end
  endtask

  task automatic test_saturation();
    int vals[5] = '{9999, 10000, 5, 16383, 7};
    logic [15:0] b; logic o, h, da; int lat, bn;
    foreach (vals[i]) begin
      run_conv(14'(vals[i]), b, o, lat, bn, h, da);
      total++; if (b !== ref_bcd(vals[i])) begin bad++; $display("FAIL sat_bcd(%0d): got %h want %h", vals[i], b, ref_bcd(vals[i])); end
      total++; if (o !== (vals[i] > 9999)) begin bad++; $display("FAIL sat_ovf(%0d): got %b want %b", vals[i], o, vals[i] > 9999); end
    end
  endtask

  task automatic test_busy_ignore();
    int k;
    @(negedge clk); start_in = 1'b1; bin_in = 14'd42;
    @(negedge clk); start_in = 1'b0; k = 1;
    repeat (4) @(negedge clk);
    k = 5;
    start_in = 1'b1; bin_in = 14'd77;
    @(negedge clk); start_in = 1'b0; bin_in = 14'd0; k++;
    while (!done_o && k < 40) begin @(negedge clk); k++; end
    total++; if (k != 15) begin bad++; $display("FAIL ignore_done_time: got %0d want 15", k); end
    total++; if (bcd_o !== 16'h0042) begin bad++; $display("FAIL ignore_bcd: got %h want 0042", bcd_o); end
    start_in = 1'b1; bin_in = 14'd77;
    @(negedge clk); start_in = 1'b0; bin_in = 14'($urandom); k = 1;
    total++; if ({done_o, busy_o} !== 2'b01) begin bad++; $display("FAIL done_cycle_accept: got %b want 01", {done_o, busy_o}); end
    while (!done_o && k < 40) begin @(negedge clk); k++; end
    total++; if (k != 15) begin bad++; $display("FAIL b2b_done_time: got %0d want 15", k); end
    total++; if (bcd_o !== 16'h0077) begin bad++; $display("FAIL b2b_bcd: got %h want 0077", bcd_o); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int dones, busies;
    @(negedge clk); start_in = 1'b1; bin_in = 14'd8888;
    @(negedge clk); start_in = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (bcd_o !== 16'h0) begin bad++; $display("FAIL async_bcd: got %h want 0000", bcd_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL async_busy: got %b want 0", busy_o); end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    dones = 0; busies = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_o) dones++;
      if (busy_o) busies++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL async_no_done: got %0d want 0", dones); end
    total++; if (busies != 0) begin bad++; $display("FAIL async_idle: got %0d want 0", busies); end
    total++; if (bcd_o !== 16'h0) begin bad++; $display("FAIL async_bcd_held: got %h want 0000", bcd_o); end
  endtask

  task automatic test_back_to_back();
    int q[$];
    int n, last, k, e;
    logic [13:0] v;
    n = 0; last = 0; k = 0;
    @(negedge clk); v = rand14(); bin_in = v; start_in = 1'b1; q.push_back(int'(v));
    while (n < 8 && k < 200) begin
      @(negedge clk); k++;
      if (done_o) begin
        e = q.pop_front();
        total++; if (bcd_o !== ref_bcd(e)) begin bad++; $display("FAIL stream_bcd(%0d): got %h want %h", e, bcd_o, ref_bcd(e)); end
        total++; if (ovf_o !== (e > 9999)) begin bad++; $display("FAIL stream_ovf(%0d): got %b want %b", e, ovf_o, e > 9999); end
        total++; if (k - last != 15) begin bad++; $display("FAIL stream_period: got %0d want 15", k - last); end
        last = k; n++;
        if (n == 8) start_in = 1'b0;
        else begin v = rand14(); bin_in = v; q.push_back(int'(v)); end
      end else begin
        bin_in = 14'($urandom);
      end
    end
    total++; if (n != 8) begin bad++; $display("FAIL stream_count: got %0d want 8", n); end
    start_in = 1'b0;
    @(negedge clk);
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL stream_done_width: got %b want 0", done_o); end
  endtask

  task automatic test_random();
    int edges[11] = '{0, 9, 10, 99, 100, 999, 1000, 9998, 9999, 10000, 16383};
    logic [15:0] b; logic o, h, da; int lat, bn, v;
    for (int i = 0; i < 161; i++) begin
      v = (i < 11) ? edges[i] : int'(rand14());
      run_conv(14'(v), b, o, lat, bn, h, da);
      total++; if (b !== ref_bcd(v)) begin bad++; $display("FAIL rand_bcd(%0d): got %h want %h", v, b, ref_bcd(v)); end
      total++; if (o !== (v > 9999)) begin bad++; $display("FAIL rand_ovf(%0d): got %b want %b", v, o, v > 9999); end
      total++; if (lat != 14 || bn != 14) begin bad++; $display("FAIL rand_timing(%0d): got lat=%0d busy=%0d want 14/14", v, lat, bn); end
      total++; if (h !== 1'b1 || da !== 1'b0) begin bad++; $display("FAIL rand_hold_pulse(%0d): got held=%b done_after=%b want 1/0", v, h, da); end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_1234();
    test_saturation();
    test_busy_ignore();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter that feeds the 4-digit multiplexed seven-segment driver's 16-bit bcd_in.
- Converts an unsigned binary value (0..9999) to four packed BCD digits using iterative shift-and-add-3 (double dabble), one bit per clock.
- Holds the last valid result on bcd_o, so the display stays stable between conversions.

Parameters:
BIN_W, 14, binary input width; must satisfy 2^BIN_W-1 >= 9999.
DIGITS, 4, number of BCD digits; bcd_o width is 4*DIGITS.
MAX_VAL, 9999, saturation value; largest value representable in DIGITS digits.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start_in  input  1  conversion request; sampled only when idle.
bin_in  input  BIN_W  unsigned binary operand; captured on the accepted start edge.
bcd_o  output  4*DIGITS  packed BCD result; digit 0 (ones) in [3:0]; drives multidigit bcd_in.
busy_o  output  1  high while a conversion is in progress.
done_o  output  1  one-cycle pulse when bcd_o has been updated.
ovf_o  output  1  sticky per result: captured operand exceeded MAX_VAL.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE, bcd_o=0, busy_o=0, done_o=0, ovf_o=0, and all scratch registers=0.
- States:
  - IDLE -> SHIFT on start_in=1 at edge E0.
  - SHIFT stays for exactly BIN_W edges, then -> IDLE.
  - No other states.
- Accept at E0 (in IDLE with start_in=1):
  - shift_reg <= bin_in; scratch BCD <= 0; bit counter <= 0.
  - ovf_pending <= (bin_in > MAX_VAL); busy_o <= 1.
- Each SHIFT edge:
  - Every scratch digit >= 5 gets +3 (combinational, all digits in parallel).
  - Then {scratch, shift_reg} shifts left by 1.
  - Counter increments.
- Final SHIFT edge (counter == BIN_W-1), i.e. edge E0+BIN_W:
  - bcd_o <= shifted scratch, or 16'h9999 (all digits 9) if ovf_pending.
  - ovf_o <= ovf_pending; done_o <= 1; busy_o <= 0; state <= IDLE.
- Latency: done_o high in the cycle following edge E0+BIN_W (14 cycles for the default width). busy_o is high for exactly BIN_W cycles.
- done_o is high for exactly one cycle; it deasserts on the next edge unless a new conversion completes.
- bcd_o changes only at completion and never shows partial results; it is held indefinitely otherwise.
- start_in while busy_o=1 is ignored; there is no queueing.
- start_in high during the done_o cycle: state is IDLE, so it is accepted (back-to-back throughput of BIN_W+1 cycles per result).
- start_in held high continuously: conversions repeat back-to-back, with bin_in re-sampled at each accept.
- bin_in changes during SHIFT have no effect.
- Reset mid-conversion aborts immediately: outputs return to reset values and no done_o pulse is produced.
- Saturation: any operand in MAX_VAL+1..2^BIN_W-1 yields bcd_o=all nines with ovf_o=1. ovf_o clears on the next non-overflow completion.

Decomposition:
- Shared package: BCD_DIGIT_W=4, ADD3_THRESH=5, state encoding (IDLE, SHIFT), and a BCD_NINES constant function of DIGITS.
- One natural sub-module: bcd_add3_digit, a combinational 4-bit "if >= 5 then +3" cell, instantiated DIGITS times.
- Counter, FSM and output registers stay in the top module.

Test Plan:
- Reset, then start with bin_in=0 -> after 14 cycles done_o pulses once, bcd_o=16'h0000, ovf_o=0; busy_o high for exactly 14 cycles.
- bin_in=1234, start -> bcd_o=16'h1234 on the done cycle; bcd_o holds 16'h0000 (prior value) on every cycle before it.
- bin_in=9999 -> 16'h9999 with ovf_o=0; then bin_in=10000 -> 16'h9999 with ovf_o=1; then bin_in=5 -> 16'h0005 with ovf_o=0.
- Start bin_in=42, re-assert start with bin_in=77 at cycle 5 -> request ignored, result 16'h0042; start with bin_in=77 during the done cycle -> accepted, 16'h0077 after 14 more cycles.
- Start bin_in=8888, assert rst_n=0 at cycle 7 -> bcd_o=0 and busy_o=0 immediately (asynchronous), no done_o; after release, idle until the next start.
- Sweep 0..9999 against a reference model (value -> digits) -> all results match; no done_o glitches; each done_o is exactly one cycle wide.
